// File: rtl/nrst_seq_pkg.sv
// Shared types and sizing helpers for the staged reset sequencer.
package nrst_seq_pkg;

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_STEP = 2'd1,
    ST_RUN  = 2'd2
  } nrst_seq_state_t;

  // Counter is wide enough to hold the longer interval without saturating.
  function automatic int cnt_width(input int hold, input int step);
    int m;
    m = (hold > step) ? hold : step;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/nrst_sequencer_if.sv
// Soft-reset request in, staged resets / status / debug state out.
// The master drives SRST_REQ_I (level, sampled every edge, no handshake); the slave owns all other signals, which are registered.
interface nrst_sequencer_if #(
  parameter int N_OUT = 4
);
  import nrst_seq_pkg::*;

  logic             SRST_REQ_I;
  logic [N_OUT-1:0] NRST_O;
  logic             READY_O;
  logic             BUSY_O;
  nrst_seq_state_t  state_dbg;

  modport master (
    output SRST_REQ_I,
    input  NRST_O, READY_O, BUSY_O, state_dbg
  );

  modport slave (
    input  SRST_REQ_I,
    output NRST_O, READY_O, BUSY_O, state_dbg
  );

endinterface

// File: rtl/nrst_seq_timer.sv
// Interval timer: counts enabled edges and flags the edge on which the count reaches limit_i.
module nrst_seq_timer #(
  parameter int CNT_W = 5
) (
  input  logic             clk_i,
  input  logic             nrst_i,
  input  logic             clear_i,
  input  logic             enable_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // cnt_q holds edges already counted, so the current edge is the limit-th one.
  assign tc_o = enable_i && !clear_i && (cnt_q == (limit_i - CNT_W'(1)));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)       cnt_d = '0;
    else if (enable_i) cnt_d = tc_o ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/nrst_sequencer.sv
// Staged reset release: hold, then one NRST_O bit per step interval, then READY_O.
// A level soft-reset request collapses every output and restarts the hold.
module nrst_sequencer
  import nrst_seq_pkg::*;
#(
  parameter int N_OUT       = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int STEP_CYCLES = 8
) (
  input  logic            CLK_I,
  input  logic            NRST_I,
  nrst_sequencer_if.slave bus
);

  localparam int CNT_W = cnt_width(HOLD_CYCLES, STEP_CYCLES);
  localparam int IDX_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  if (N_OUT < 1 || HOLD_CYCLES < 1 || STEP_CYCLES < 1) begin : g_bad_params
    $error("nrst_sequencer: N_OUT, HOLD_CYCLES and STEP_CYCLES must all be >= 1");
  end

  nrst_seq_state_t  state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [N_OUT-1:0] nrst_q, nrst_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             srst;
  logic             tc;
  logic             last;
  logic [CNT_W-1:0] limit;

  assign srst  = bus.SRST_REQ_I;
  assign last  = (idx_q == IDX_W'(N_OUT - 1));
  assign limit = (state_q == ST_HOLD) ? CNT_W'(HOLD_CYCLES) : CNT_W'(STEP_CYCLES);

  nrst_seq_timer #(.CNT_W(CNT_W)) u_timer (
    .clk_i    (CLK_I),
    .nrst_i   (NRST_I),
    .clear_i  (srst),
    .enable_i (state_q != ST_RUN),
    .limit_i  (limit),
    .tc_o     (tc)
  );

  always_ff @(posedge CLK_I or negedge NRST_I) begin
    if (!NRST_I) begin
      state_q <= ST_HOLD;
      idx_q   <= '0;
      nrst_q  <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      nrst_q  <= nrst_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (srst) begin
      state_d = ST_HOLD;
    end else begin
      case (state_q)
        ST_HOLD: if (tc) state_d = (N_OUT == 1) ? ST_RUN : ST_STEP;
        ST_STEP: if (tc && last) state_d = ST_RUN;
        ST_RUN:  state_d = ST_RUN;
        default: state_d = ST_HOLD;
      endcase
    end
  end

  // Soft request has priority, so a release due on the same edge never happens.
  always_comb begin
    nrst_d  = nrst_q;
    idx_d   = idx_q;
    ready_d = (state_d == ST_RUN);
    busy_d  = (state_d != ST_RUN);
    if (srst) begin
      nrst_d = '0;
      idx_d  = '0;
    end else if (tc) begin
      for (int i = 0; i < N_OUT; i++) begin
        if (IDX_W'(i) == idx_q) nrst_d[i] = 1'b1;
      end
      if (!last) idx_d = idx_q + IDX_W'(1);
    end
  end

  assign bus.NRST_O    = nrst_q;
  assign bus.READY_O   = ready_q;
  assign bus.BUSY_O    = busy_q;
  assign bus.state_dbg = state_q;

  // Released bits always form a contiguous run from bit 0.
  a_thermometer: assert property (@(posedge CLK_I) disable iff (!NRST_I)
    (nrst_q & (nrst_q + N_OUT'(1))) == '0);

endmodule

// File: doc/nrst_sequencer.md
Name: nrst_sequencer

Overview:
- Sits directly downstream of the reset synchronizer and consumes its synchronized active-low reset.
- Generates N_OUT staged, registered active-low reset outputs for sub-blocks.
- Release order: a minimum hold time, then one output at a time at a fixed interval, then READY_O.
- A synchronous soft-reset request re-asserts every output and restarts the sequence.

Parameters:
- N_OUT, 4, number of sequenced reset outputs (>=1).
- HOLD_CYCLES, 16, clock edges with reset inactive before NRST_O[0] releases (>=1).
- STEP_CYCLES, 8, clock edges between successive releases (>=1).
- CNT_W (localparam), $clog2(max(HOLD_CYCLES,STEP_CYCLES)+1), timer width.

Ports:
- CLK_I  input  1  single system clock.
- NRST_I  input  1  asynchronous active-low reset; in system use this is the synchronizer output, so deassertion is synchronous to CLK_I.
- SRST_REQ_I  input  1  synchronous soft-reset request, level-sensitive, active-high.
- NRST_O  output  N_OUT  staged active-low resets; bit 0 releases first.
- READY_O  output  1  high once all NRST_O bits are released.
- BUSY_O  output  1  high while the sequence is in progress (state != ST_RUN).

Behaviour:
- Reset
  - NRST_I=0 asynchronously forces NRST_O='0, READY_O=0, BUSY_O=1, state ST_HOLD, timer=0, idx=0.
- Outputs
  - All outputs are registered; no combinational path from any input to any output.
- Edge numbering
  - Edge 1 is the first rising CLK_I edge with NRST_I=1 and SRST_REQ_I=0.
- ST_HOLD
  - Timer increments each edge.
  - At edge HOLD_CYCLES: NRST_O[0]<=1, timer<=0, idx<=1.
  - If N_OUT=1: READY_O<=1 and go to ST_RUN on that same edge; otherwise go to ST_STEP.
- ST_STEP
  - Timer increments each edge.
  - When it reaches STEP_CYCLES: NRST_O[idx]<=1, idx++, timer<=0.
  - Releasing bit N_OUT-1 sets READY_O<=1, BUSY_O<=0 and moves to ST_RUN on the same edge.
- Release times with defaults: NRST_O[i] rises at edge HOLD_CYCLES + i*STEP_CYCLES; READY_O rises at edge HOLD_CYCLES + (N_OUT-1)*STEP_CYCLES.
- ST_RUN
  - Holds all outputs at 1.
  - SRST_REQ_I=1 sampled at any edge returns the block to the reset values (except that it is synchronous) and moves to ST_HOLD.
- Soft reset in any state
  - While SRST_REQ_I=1, every edge clears timer/idx and keeps NRST_O='0, READY_O=0, BUSY_O=1.
  - The first edge with SRST_REQ_I=0 counts as edge 1 of a fresh hold.
- Mid-sequence events
  - Soft request in ST_HOLD/ST_STEP aborts: already-released bits return to 0.
  - An NRST_I assertion mid-sequence does the same asynchronously.
- Invariant: NRST_O is always thermometer-coded, (NRST_O[i]=1 implies NRST_O[j]=1 for all j<i). This must be proven by assertion.
- Simultaneous events: a soft request on the same edge a release would occur wins; no bit releases.
- Timer width: CNT_W sized so neither interval saturates. Terminal compare is equality on the counter. There is no wrap-around in normal operation.
- Illegal parameters (any parameter below 1) trigger an elaboration-time $error.

Decomposition:
- Package nrst_seq_pkg:
  - typedef enum logic [1:0] {ST_HOLD, ST_STEP, ST_RUN} nrst_seq_state_t
  - function cnt_width(hold, step) returning CNT_W
- One natural sub-module: nrst_seq_timer.
  - Interface: clear input, enable input, terminal-count compare against a runtime limit, tc output.
  - Reused for both the HOLD and STEP intervals.
- The top level holds the FSM, idx counter and output registers.

Test Plan:
- Defaults, NRST_I 0->1, SRST_REQ_I=0:
  - NRST_O steps 0000->0001@edge16->0011@24->0111@32->1111@40.
  - READY_O=1 and BUSY_O=0 at edge 40.
- NRST_I pulsed low at edge 28 (NRST_O=0011): NRST_O=0000 and READY_O=0 immediately, without waiting for a clock edge; the sequence restarts from edge 1 after release.
- In ST_RUN, SRST_REQ_I high for 5 edges then low:
  - NRST_O=0000 from the first sampled edge.
  - NRST_O[0] rises 16 edges after the first low edge.
  - Full sequence completes 24 more edges later.
- SRST_REQ_I asserted on the exact edge NRST_O[2] would rise (edge 32): NRST_O goes 0011->0000; bit 2 never glitches high.
- N_OUT=1, HOLD_CYCLES=1, STEP_CYCLES=1: NRST_O[0] and READY_O both rise at edge 1.
- Random NRST_I/SRST_REQ_I stimulus for 10k cycles: thermometer invariant holds; READY_O=1 iff NRST_O all ones and state ST_RUN.
